// File: rtl/multichannel_sample_enable_gen.sv
// rtl/multichannel_sample_enable_gen.sv - NUM_CH sample-enable strobes with divide, phase and burst control
// Optional per-channel pulse counters: define SAMPLE_EN_GEN_PULSE_CNT_EN.
module multichannel_sample_enable_gen #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 16
) (
  input  logic                      clk,
  input  logic                      a_rst,
  input  logic [NUM_CH*CNT_W-1:0]   i_div_reg,
  input  logic [NUM_CH*CNT_W-1:0]   i_phase_reg,
  input  logic [NUM_CH*BURST_W-1:0] i_burst_reg,
  input  logic [31:0]               i_ctrl_reg,
  output logic [NUM_CH-1:0]         o_sample_en,
  output logic [NUM_CH-1:0]         o_done,
`ifdef SAMPLE_EN_GEN_PULSE_CNT_EN
  output logic [NUM_CH*32-1:0]      o_pulse_cnt,
`endif
  output logic                      o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_PHASE, S_RUN, S_DONE} state_t;

  logic              r_start_q;
  logic              w_srst;
  logic              w_start;
  logic              w_burst_mode;
  logic              w_rise;
  logic [NUM_CH-1:0] w_en;
  logic [NUM_CH-1:0] w_busy_vec;
  logic              w_unused_ctrl;

  assign w_srst        = i_ctrl_reg[0];
  assign w_start       = i_ctrl_reg[1];
  assign w_burst_mode  = i_ctrl_reg[2];
  assign w_en          = i_ctrl_reg[16 +: NUM_CH];
  assign w_rise        = w_start & ~r_start_q;
  assign w_unused_ctrl = ^i_ctrl_reg;
  assign o_busy        = |w_busy_vec;

  // start_q keeps tracking START during SRST so a held START cannot relaunch
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= w_start;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_div;
    logic [CNT_W-1:0]   w_reload;
    logic [CNT_W-1:0]   w_phase;
    logic [BURST_W-1:0] r_bcnt;
    logic [BURST_W-1:0] w_bcnt_nxt;
    logic [BURST_W-1:0] w_blen;
    logic [BURST_W:0]   w_bcnt_inc;
    logic               w_burst_on;
    logic               w_pulse_nxt;
    logic               r_sample_en;

    assign w_div      = i_div_reg[n*CNT_W +: CNT_W];
    assign w_phase    = i_phase_reg[n*CNT_W +: CNT_W];
    assign w_blen     = i_burst_reg[n*BURST_W +: BURST_W];
    assign w_reload   = (w_div == '0) ? '0 : w_div - CNT_W'(1);
    assign w_burst_on = w_burst_mode && (w_blen != '0);
    assign w_bcnt_inc = {1'b0, r_bcnt} + (BURST_W+1)'(1);

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bcnt_nxt  = r_bcnt;
      w_pulse_nxt = 1'b0;
      if (r_state != S_IDLE && (!w_start || !w_en[n])) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_rise && w_en[n]) begin
              w_state_nxt = S_PHASE;
              w_cnt_nxt   = w_phase;
              w_bcnt_nxt  = '0;
            end
          end
          S_PHASE, S_RUN: begin
            if (r_cnt == '0) begin
              w_pulse_nxt = 1'b1;
              w_cnt_nxt   = w_reload;
              w_state_nxt = S_RUN;
              // >= so a live shrink of B below the current count still terminates
              if (w_burst_on) begin
                if (w_bcnt_inc >= {1'b0, w_blen}) begin
                  w_state_nxt = S_DONE;
                  w_bcnt_nxt  = w_blen;
                end else begin
                  w_bcnt_nxt = w_bcnt_inc[BURST_W-1:0];
                end
              end
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_bcnt      <= '0;
        r_sample_en <= 1'b0;
      end else if (w_srst) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_bcnt      <= '0;
        r_sample_en <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_cnt       <= w_cnt_nxt;
        r_bcnt      <= w_bcnt_nxt;
        r_sample_en <= w_pulse_nxt;
      end
    end

    assign o_sample_en[n] = r_sample_en;
    assign o_done[n]      = (r_state == S_DONE);
    assign w_busy_vec[n]  = (r_state == S_PHASE) || (r_state == S_RUN);

`ifdef SAMPLE_EN_GEN_PULSE_CNT_EN
    logic [31:0] r_pulse_cnt;

    always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
        r_pulse_cnt <= '0;
      end else if (w_srst || w_rise) begin
        r_pulse_cnt <= '0;
      end else if (w_pulse_nxt) begin
        r_pulse_cnt <= r_pulse_cnt + 32'd1;
      end
    end

    assign o_pulse_cnt[n*32 +: 32] = r_pulse_cnt;
`endif
  end

endmodule
